// File: rtl/wam_pkg.sv
// Shared constants and the level-to-parameter map for the Whac-A-Mole level controller.
package wam_pkg;

    localparam int RTO_MAX = 100;

    function automatic int LVL_W(input int n);
        return $clog2(n);
    endfunction

    // Mole lifetime: signed 6-bit so that a large level cannot wrap below the floor.
    function automatic logic [3:0] age_map(input int lvl, input int base, input int step, input int amin);
        logic signed [5:0] a;
        logic signed [5:0] m;
        a = 6'(base - lvl * step);
        m = 6'(amin);
        if (a < m) begin
            a = m;
        end else begin
            a = a;
        end
        return a[3:0];
    endfunction

    function automatic logic [7:0] rto_map(input int lvl, input int base, input int step);
        logic [9:0] r;
        r = 10'(base + lvl * step);
        if (r > 10'(RTO_MAX)) begin
            r = 10'(RTO_MAX);
        end else begin
            r = r;
        end
        return r[7:0];
    endfunction

endpackage

// File: rtl/wam_dbn.sv
// Button debouncer: one tch pulse after DB_CNT consecutive high samples, re-armed only by a low sample.
module wam_dbn #(
    parameter int DB_CNT = 5
) (
    input  logic clk_19,
    input  logic rst,
    input  logic start,
    input  logic btn,
    output logic tch
);

    logic       r_btn;
    logic       r_btn_d;
    logic       r_tch;
    logic [3:0] r_cnt;
    logic       w_rise;

    assign w_rise = r_btn & ~r_btn_d;
    assign tch    = r_tch;

    // Treat the input as already high on rst/start so a press held across it never re-triggers.
    always_ff @(posedge clk_19) begin
        if (rst || start) begin
            r_btn   <= 1'b1;
            r_btn_d <= 1'b1;
            r_cnt   <= 4'd0;
            r_tch   <= 1'b0;
        end else begin
            r_btn   <= btn;
            r_btn_d <= r_btn;
            r_tch   <= 1'b0;
            if (r_cnt == 4'd0) begin
                if (w_rise) begin
                    r_cnt <= 4'd1;
                end else begin
                    r_cnt <= 4'd0;
                end
            end else if (r_cnt == 4'(DB_CNT)) begin
                r_tch <= 1'b1;
                r_cnt <= 4'd0;
            end else if (r_btn) begin
                r_cnt <= r_cnt + 4'd1;
            end else begin
                r_cnt <= 4'd0;
            end
        end
    end

endmodule

// File: rtl/wam_lvl.sv
// Whac-A-Mole difficulty controller: debounced level counter with registered age/rto map.
// Define WAM_LVL_AUTODOWN_EN to step the level down after MISS_LIM consecutive misses.
module wam_lvl
    import wam_pkg::*;
#(
    parameter int NUM_LVL   = 4,
    parameter int MIN_LVL   = 1,
    parameter int START_LVL = 1,
    parameter int DB_CNT    = 5,
    parameter int AGE_BASE  = 14,
    parameter int AGE_STEP  = 2,
    parameter int AGE_MIN   = 3,
    parameter int RTO_BASE  = 42,
    parameter int RTO_STEP  = 15,
    parameter int MISS_LIM  = 4
) (
    input  logic                         clk_19,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         lft,
    input  logic                         rgt,
    input  logic                         cout0,
    input  logic                         hit,
    input  logic                         miss,
    output logic [LVL_W(NUM_LVL)-1:0]    lvl,
    output logic [3:0]                   age,
    output logic [7:0]                   rto,
    output logic                         lvl_chg
);

    localparam int LW = LVL_W(NUM_LVL);

    logic [LW-1:0] r_lvl;
    logic [LW-1:0] w_lvl_nxt;
    logic [3:0]    r_age;
    logic [7:0]    r_rto;
    logic          r_chg;
    logic          w_tch_lft;
    logic          w_tch_rgt;
    logic          w_tch_cout;
    logic          w_ez;
    logic          w_hd;

    wam_dbn #(.DB_CNT(DB_CNT)) u_dbn_lft  (.clk_19(clk_19), .rst(rst), .start(start), .btn(lft),   .tch(w_tch_lft));
    wam_dbn #(.DB_CNT(DB_CNT)) u_dbn_rgt  (.clk_19(clk_19), .rst(rst), .start(start), .btn(rgt),   .tch(w_tch_rgt));
    wam_dbn #(.DB_CNT(DB_CNT)) u_dbn_cout (.clk_19(clk_19), .rst(rst), .start(start), .btn(cout0), .tch(w_tch_cout));

    assign w_ez = w_tch_lft;
    assign w_hd = w_tch_rgt | w_tch_cout;

`ifdef WAM_LVL_AUTODOWN_EN
    localparam int MW = $clog2(MISS_LIM + 1);

    logic [MW-1:0] r_miss;
    logic          w_auto;

    assign w_auto = (r_miss == MW'(MISS_LIM)) && !w_ez && !w_hd && !start;

    // Streak clears even when the auto step-down is saturated at MIN_LVL.
    always_ff @(posedge clk_19) begin
        if (rst || start) begin
            r_miss <= '0;
        end else if (w_lvl_nxt != r_lvl) begin
            r_miss <= '0;
        end else if (w_auto || hit) begin
            r_miss <= '0;
        end else if (miss && (r_miss < MW'(MISS_LIM))) begin
            r_miss <= r_miss + MW'(1);
        end else begin
            r_miss <= r_miss;
        end
    end
`else
    logic w_unused;
    assign w_unused = hit | miss;
`endif

    // Next level: start > easier > harder > auto-down, each saturating at its bound.
    always_comb begin
        w_lvl_nxt = r_lvl;
        if (start) begin
            w_lvl_nxt = LW'(START_LVL);
        end else if (w_ez) begin
            if (r_lvl > LW'(MIN_LVL)) begin
                w_lvl_nxt = r_lvl - LW'(1);
            end else begin
                w_lvl_nxt = r_lvl;
            end
        end else if (w_hd) begin
            if (r_lvl < LW'(NUM_LVL - 1)) begin
                w_lvl_nxt = r_lvl + LW'(1);
            end else begin
                w_lvl_nxt = r_lvl;
            end
`ifdef WAM_LVL_AUTODOWN_EN
        end else if (w_auto) begin
            if (r_lvl > LW'(MIN_LVL)) begin
                w_lvl_nxt = r_lvl - LW'(1);
            end else begin
                w_lvl_nxt = r_lvl;
            end
`endif
        end else begin
            w_lvl_nxt = r_lvl;
        end
    end

    // Level, map outputs and change strobe all move on the same edge.
    always_ff @(posedge clk_19) begin
        if (rst) begin
            r_lvl <= LW'(START_LVL);
            r_age <= age_map(START_LVL, AGE_BASE, AGE_STEP, AGE_MIN);
            r_rto <= rto_map(START_LVL, RTO_BASE, RTO_STEP);
            r_chg <= 1'b0;
        end else begin
            r_lvl <= w_lvl_nxt;
            r_age <= age_map(int'(w_lvl_nxt), AGE_BASE, AGE_STEP, AGE_MIN);
            r_rto <= rto_map(int'(w_lvl_nxt), RTO_BASE, RTO_STEP);
            r_chg <= (w_lvl_nxt != r_lvl);
        end
    end

    assign lvl     = r_lvl;
    assign age     = r_age;
    assign rto     = r_rto;
    assign lvl_chg = r_chg;

endmodule

// File: tb/tb_wam_lvl.sv
// Scoreboard bench for wam_lvl: a model pushes each expected level change, a monitor pops on lvl_chg.
module tb_wam_lvl;

    localparam int NUM_LVL = 4;
    localparam int MIN_L   = 1;
    localparam int MAX_L   = NUM_LVL - 1;
    localparam int START_L = 1;
    localparam int DB      = 5;
    localparam int LIM     = 4;

    logic       clk_19 = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       lft = 1'b0;
    logic       rgt = 1'b0;
    logic       cout0 = 1'b0;
    logic       hit = 1'b0;
    logic       miss = 1'b0;
    logic [1:0] lvl;
    logic [3:0] age;
    logic [7:0] rto;
    logic       lvl_chg;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int l;
        int a;
        int r;
    } exp_t;
    exp_t exp_q[$];

    int m_lvl    = START_L;
    int m_streak = 0;

    wam_lvl dut (
        .clk_19(clk_19), .rst(rst), .start(start), .lft(lft), .rgt(rgt), .cout0(cout0),
        .hit(hit), .miss(miss), .lvl(lvl), .age(age), .rto(rto), .lvl_chg(lvl_chg)
    );

    always #5 clk_19 = ~clk_19;

    function automatic int ref_age(input int l);
        int v;
        v = 14 - 2 * l;
        return (v < 3) ? 3 : v;
    endfunction

    function automatic int ref_rto(input int l);
        int v;
        v = 42 + 15 * l;
        return (v > 100) ? 100 : v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Move the model to a new level; a real change is queued for the monitor.
    task automatic model_set(input int nl);
        exp_t e;
        if (nl != m_lvl) begin
            e.l = nl;
            e.a = ref_age(nl);
            e.r = ref_rto(nl);
            exp_q.push_back(e);
            m_streak = 0;
        end
        m_lvl = nl;
    endtask

    task automatic model_btn(input bit ez, input bit hd);
        if (ez) begin
            model_set((m_lvl > MIN_L) ? m_lvl - 1 : m_lvl);
        end else if (hd) begin
            model_set((m_lvl < MAX_L) ? m_lvl + 1 : m_lvl);
        end
    endtask

    task automatic model_miss(input bit is_hit);
        if (is_hit) begin
            m_streak = 0;
        end else begin
            m_streak = (m_streak < LIM) ? m_streak + 1 : LIM;
`ifdef WAM_LVL_AUTODOWN_EN
            if (m_streak == LIM) begin
                model_set((m_lvl > MIN_L) ? m_lvl - 1 : m_lvl);
                m_streak = 0;
            end
`endif
        end
    endtask

    // Monitor: every lvl_chg pulse must match the oldest queued expectation.
    always @(negedge clk_19) begin
        exp_t e;
        if (!rst && lvl_chg) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_lvl_chg: got lvl %0d, expected no change", lvl);
            end else begin
                e = exp_q.pop_front();
                chk("sb_lvl", int'(lvl), e.l);
                chk("sb_age", int'(age), e.a);
                chk("sb_rto", int'(rto), e.r);
            end
        end
    end

    task automatic press(input bit l, input bit r, input bit c, input int len);
        if (len >= DB) model_btn(l, r | c);
        @(negedge clk_19);
        lft = l; rgt = r; cout0 = c;
        repeat (len) @(posedge clk_19);
        @(negedge clk_19);
        lft = 1'b0; rgt = 1'b0; cout0 = 1'b0;
        repeat (DB + 4) @(negedge clk_19);
    endtask

    task automatic pulse_hm(input bit is_hit);
        model_miss(is_hit);
        @(negedge clk_19);
        hit = is_hit; miss = ~is_hit;
        @(negedge clk_19);
        hit = 1'b0; miss = 1'b0;
        repeat (3) @(negedge clk_19);
    endtask

    task automatic do_start();
        model_set(START_L);
        m_streak = 0;
        @(negedge clk_19);
        start = 1'b1;
        @(negedge clk_19);
        start = 1'b0;
        repeat (3) @(negedge clk_19);
    endtask

    initial begin
        int cyc;
        int mask;
        int len;
        int op;

        repeat (2) @(posedge clk_19);
        @(negedge clk_19);
        rst = 1'b0;
        chk("reset_lvl", int'(lvl), 1);
        chk("reset_age", int'(age), 12);
        chk("reset_rto", int'(rto), 57);
        chk("reset_chg", int'(lvl_chg), 0);
        repeat (3) @(negedge clk_19);

        // Press latency: first high sample is edge 1, level moves on edge DB+3.
        model_btn(1'b0, 1'b1);
        rgt = 1'b1;
        cyc = 0;
        while (cyc < 40) begin
            @(posedge clk_19);
            cyc++;
            @(negedge clk_19);
            if (cyc == 6) rgt = 1'b0;
            if (lvl_chg) break;
        end
        rgt = 1'b0;
        chk("press_latency", cyc, DB + 3);
        repeat (DB + 4) @(negedge clk_19);
        chk("accept_lvl", int'(lvl), 2);
        chk("accept_age", int'(age), 10);
        chk("accept_rto", int'(rto), 72);

        press(1'b0, 1'b1, 1'b0, 3);
        chk("glitch_lvl", int'(lvl), 2);

        do_start();
        repeat (4) press(1'b0, 1'b1, 1'b0, 6);
        chk("sat_hi_lvl", int'(lvl), 3);
        chk("sat_hi_age", int'(age), 8);
        chk("sat_hi_rto", int'(rto), 87);
        repeat (3) press(1'b1, 1'b0, 1'b0, 6);
        chk("sat_lo_lvl", int'(lvl), 1);

        press(1'b0, 1'b0, 1'b1, 7);
        chk("cout_lvl", int'(lvl), 2);
        press(1'b1, 1'b1, 1'b0, 6);
        chk("simul_lvl", int'(lvl), 1);

        repeat (2) press(1'b0, 1'b1, 1'b0, 6);
        repeat (4) pulse_hm(1'b0);
        chk("autodown_lvl", int'(lvl), m_lvl);
        press(1'b0, 1'b1, 1'b0, 6);
        repeat (3) pulse_hm(1'b0);
        pulse_hm(1'b1);
        repeat (3) pulse_hm(1'b0);
        chk("hit_break_lvl", int'(lvl), m_lvl);
        repeat (8) pulse_hm(1'b0);
        chk("miss8_lvl", int'(lvl), m_lvl);

        // Start while the rgt count sits at 3: the in-flight press must be lost.
        press(1'b0, 1'b1, 1'b0, 6);
        @(negedge clk_19);
        rgt = 1'b1;
        repeat (4) @(posedge clk_19);
        model_set(START_L);
        m_streak = 0;
        @(negedge clk_19);
        start = 1'b1;
        @(negedge clk_19);
        start = 1'b0;
        repeat (10) @(negedge clk_19);
        rgt = 1'b0;
        repeat (DB + 4) @(negedge clk_19);
        chk("midpress_start_lvl", int'(lvl), 1);

        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 9);
            if (op <= 5) begin
                mask = $urandom_range(1, 7);
                len  = $urandom_range(1, 9);
                press(mask[0], mask[1], mask[2], len);
            end else if (op <= 7) begin
                pulse_hm(1'b0);
            end else if (op == 8) begin
                pulse_hm(1'b1);
            end else begin
                do_start();
            end
        end

        repeat (10) @(negedge clk_19);
        chk("final_lvl", int'(lvl), m_lvl);
        chk("final_age", int'(age), ref_age(m_lvl));
        chk("final_rto", int'(rto), ref_rto(m_lvl));
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
